seq_uart_tx: RTL and testbench

Downstream stage for the sequence-generator outputs. It captures 8-bit sequence samples (squares, Fibonacci, Pell, etc.) on a valid strobe and buffers them in a small synchronous FIFO. It then serialises each sample as an 8N1 UART frame on a single pin, so an external host can log the sequences. It sits between the output-select mux and a spare uio pin.

---
 rtl/seq_uart_pkg.sv | 10 +
 rtl/seq_sync_fifo.sv | 53 +++++
 rtl/seq_uart_tx.sv | 138 +++++++++++++
 tb/tb_seq_uart_tx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_uart_pkg.sv
// Shared types and frame constants for the sequence UART transmitter.
package seq_uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int FRAME_BITS = 10;
  // Start and stop bits frame the payload.
  localparam int DATA_BITS  = FRAME_BITS - 2;

endpackage

// File: rtl/seq_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read; pointers wrap modulo DEPTH.
module seq_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  // Guard here as well so the count can never over- or underflow.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/seq_uart_tx.sv
// Buffers 8-bit sequence samples and serialises them as 8N1 UART frames on tx.
module seq_uart_tx
  import seq_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sample_valid,
  input  logic [7:0]             sample_data,
  input  logic                   ovf_clear,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   full,
  output logic                   overflow
);

  localparam int              BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      BIT_LAST  = 3'(DATA_BITS - 1);

  tx_state_t     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;

  logic          pop, push, empty, baud_done;
  logic [7:0]    head;

  assign push = sample_valid & (~full | pop);

  seq_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (sample_data),
    .rdata (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  assign baud_done = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    tx_d    = 1'b1;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          bit_d   = '0;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is derived from the next state so the registered pin lines up with the state.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase

    // A drop outranks a simultaneous clear.
    if (sample_valid && !push) ovf_d = 1'b1;
    else if (ovf_clear)        ovf_d = 1'b0;
    else                       ovf_d = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != IDLE);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_uart_tx.sv
// Scoreboard bench: stimulus queues expected bytes, a UART monitor decodes tx and compares.
module tb_seq_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_valid = 1'b0;
  logic [7:0] sample_data = 8'h00;
  logic       ovf_clear = 1'b0;
  logic       tx, busy, full, overflow;
  logic [2:0] fifo_count;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  logic [7:0] exp_q[$];
  int         starts[$];

  seq_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .ovf_clear    (ovf_clear),
    .tx           (tx),
    .busy         (busy),
    .fifo_count   (fifo_count),
    .full         (full),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // UART monitor, sampling on the falling edge.
  initial begin : monitor
    logic       active;
    logic       ok;
    int         cnt;
    logic [7:0] b;
    active = 1'b0;
    ok = 1'b1;
    cnt = 0;
    b = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        active = 1'b0;
      end else if (!active) begin
        if (tx === 1'b0) begin
          active = 1'b1;
          cnt = 0;
          ok = 1'b1;
          starts.push_back(cyc);
        end
      end else begin
        cnt++;
        if (cnt < CPB) begin
          if (tx !== 1'b0) ok = 1'b0;
        end else if (cnt < 9*CPB) begin
          if ((cnt % CPB) == 0) b[(cnt/CPB)-1] = tx;
          else if (tx !== b[(cnt/CPB)-1]) ok = 1'b0;
        end else begin
          if (tx !== 1'b1) ok = 1'b0;
          if (cnt == 10*CPB-1) begin
            active = 1'b0;
            check("frame_format", {31'd0, ok}, 32'd1);
            check("frame_expected", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) check("frame_data", {24'd0, b}, {24'd0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
    next_cycle();
    sample_valid = 1'b0;
  endtask

  task automatic wait_tx_low(output int t);
    for (int i = 0; i < 300 && tx !== 1'b0; i++) next_cycle();
    check("start_bit_seen", {31'd0, tx}, 32'd0);
    t = cyc;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 1500 && (busy !== 1'b0 || fifo_count !== 3'd0); i++) next_cycle();
    repeat (3) next_cycle();
    check("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  initial begin : stim
    int t, n, s0;
    logic [7:0] fib [5];
    fib[0] = 8'd1; fib[1] = 8'd1; fib[2] = 8'd2; fib[3] = 8'd3; fib[4] = 8'd5;

    // Reset values
    reset = 1'b1;
    repeat (3) next_cycle();
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    next_cycle();

    // 1: single frame 0x8D, latency and duration
    exp_q.push_back(8'h8D);
    push(8'h8D);
    check("t1_c1_tx", {31'd0, tx}, 32'd1);
    check("t1_c1_busy", {31'd0, busy}, 32'd0);
    check("t1_c1_count", {29'd0, fifo_count}, 32'd1);
    next_cycle();
    check("t1_c2_tx", {31'd0, tx}, 32'd0);
    check("t1_c2_busy", {31'd0, busy}, 32'd1);
    check("t1_c2_count", {29'd0, fifo_count}, 32'd0);
    n = 1;
    for (int i = 0; i < 100 && busy === 1'b1; i++) begin
      next_cycle();
      if (busy === 1'b1) n++;
    end
    check("t1_busy_cycles", n, 32'd40);
    check("t1_count_end", {29'd0, fifo_count}, 32'd0);
    wait_idle();

    // 2: five consecutive pushes; the first pop frees a slot for 0x05
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(8'(i));
      push(8'(i));
    end
    check("t2_ovf", {31'd0, overflow}, 32'd0);
    check("t2_full", {31'd0, full}, 32'd1);
    wait_idle();
    check("t2_all_sent", exp_q.size(), 32'd0);

    // 3: drops while full during STOP, set beats clear
    exp_q.push_back(8'h11);
    push(8'h11);
    wait_tx_low(t);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h21 + 8'(i));
      push(8'h21 + 8'(i));
    end
    check("t3_full", {31'd0, full}, 32'd1);
    repeat (31) next_cycle();
    sample_valid = 1'b1;
    sample_data  = 8'hAA;
    next_cycle();
    check("t3_ovf_set", {31'd0, overflow}, 32'd1);
    sample_data = 8'hBB;
    ovf_clear   = 1'b1;
    next_cycle();
    sample_valid = 1'b0;
    check("t3_set_wins", {31'd0, overflow}, 32'd1);
    next_cycle();
    ovf_clear = 1'b0;
    check("t3_ovf_cleared", {31'd0, overflow}, 32'd0);
    wait_idle();
    check("t3_all_sent", exp_q.size(), 32'd0);

    // 4: 0x00 then 0xFF with a single idle cycle between frames
    s0 = starts.size();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    push(8'h00);
    push(8'hFF);
    wait_tx_low(t);
    for (int i = 0; i < 200 && (busy !== 1'b0 || fifo_count !== 3'd0); i++) begin
      next_cycle();
      if (cyc == t + 40) begin
        check("t4_gap_tx", {31'd0, tx}, 32'd1);
        check("t4_gap_busy", {31'd0, busy}, 32'd0);
      end
      if (cyc == t + 41) check("t4_second_start", {31'd0, tx}, 32'd0);
    end
    check("t4_total_cycles", cyc - t, 32'd81);
    wait_idle();
    check("t4_frames", starts.size() - s0, 32'd2);
    if (starts.size() - s0 >= 2) check("t4_start_spacing", starts[s0+1] - starts[s0], 32'd41);

    // 5: reset mid-DATA flushes everything
    exp_q.push_back(8'h5A);
    push(8'h5A);
    push(8'h66);
    push(8'h77);
    wait_tx_low(t);
    repeat (10) next_cycle();
    reset = 1'b1;
    exp_q.delete();
    next_cycle();
    check("t5_tx", {31'd0, tx}, 32'd1);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_count", {29'd0, fifo_count}, 32'd0);
    reset = 1'b0;
    s0 = starts.size();
    repeat (60) next_cycle();
    check("t5_no_frames", starts.size() - s0, 32'd0);
    check("t5_tx_idle", {31'd0, tx}, 32'd1);

    // 6: Fibonacci stream, push+pop at full leaves count at 4
    exp_q.push_back(8'h08);
    push(8'h08);
    wait_tx_low(t);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(fib[i]);
      push(fib[i]);
    end
    check("t6_pre_count", {29'd0, fifo_count}, 32'd4);
    repeat (35) next_cycle();
    check("t6_idle_count", {29'd0, fifo_count}, 32'd4);
    exp_q.push_back(fib[4]);
    push(fib[4]);
    check("t6_count_hold", {29'd0, fifo_count}, 32'd4);
    check("t6_full_hold", {31'd0, full}, 32'd1);
    check("t6_ovf", {31'd0, overflow}, 32'd0);
    wait_idle();
    check("t6_all_sent", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
